// File: rtl/conware_row_engine.sv
// -----------------------------------------------------------------------------
// conware_row_engine
//
// Computes one Game-of-Life generation for a WIDTH x HEIGHT grid, one row at a
// time. Current-generation rows stream in on the in_* handshake (row 0 first).
// Next-generation rows stream out on the out_* handshake in the same order.
// Cells outside the grid are treated as dead; the grid does not wrap.
//
// The engine holds two rows: prev and curr. When the row below curr arrives,
// all three rows are available, so the next-generation value of curr is
// produced. The last row has no row below it. Its output is produced in FLUSH
// with an all-zero row below.
//
// Ports
//   clk        in   1      system clock
//   rstn       in   1      asynchronous, active-low reset
//   in_data    in   WIDTH  current-generation row (bit i = column i)
//   in_valid   in   1      in_data valid
//   in_ready   out  1      engine accepts a row this cycle
//   out_data   out  WIDTH  next-generation row (registered)
//   out_valid  out  1      out_data valid
//   out_ready  in   1      downstream accepts out_data
//   frame_done out  1      pulse coincident with the handshake of the last
//                          output row of a frame
// -----------------------------------------------------------------------------
module conware_row_engine #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);

    // row_cnt counts accepted rows and reaches HEIGHT at most, so one extra bit
    // above $clog2(HEIGHT) keeps it from wrapping inside a frame.
    localparam int                CNT_W      = $clog2(HEIGHT) + 1;
    localparam logic [CNT_W-1:0]  LAST_ROW   = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam bit                SINGLE_ROW = (HEIGHT == 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] curr_q, curr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;

    logic             out_slot_free;
    logic             out_fire;
    logic [WIDTH-1:0] nxt_row;
    logic [WIDTH-1:0] rule_row;

    // The rows are padded with a dead cell on each side, so the edge columns
    // need no special case in the per-cell neighbour sum.
    logic [WIDTH+1:0] prev_pad;
    logic [WIDTH+1:0] curr_pad;
    logic [WIDTH+1:0] nxt_pad;

    // The output register can take new data if it is empty, or if its
    // current contents leave in this same cycle.
    assign out_slot_free = !out_valid_q || out_ready;
    assign out_fire      = out_valid_q && out_ready;

    // In FLUSH there is no row below the last row, so all of its cells are dead.
    assign nxt_row  = (state_q == FLUSH) ? '0 : in_data;

    assign prev_pad = {1'b0, prev_q,  1'b0};
    assign curr_pad = {1'b0, curr_q,  1'b0};
    assign nxt_pad  = {1'b0, nxt_row, 1'b0};

    // Cell gi of curr sits at padded index gi+1. Its neighbours are at padded
    // indices gi, gi+1 and gi+2 in the rows above and below. In curr itself,
    // the neighbours are only at gi and gi+2.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic [3:0] n_live;

        assign n_live = 4'(prev_pad[gi]) + 4'(prev_pad[gi+1]) + 4'(prev_pad[gi+2])
                      + 4'(curr_pad[gi])                      + 4'(curr_pad[gi+2])
                      + 4'(nxt_pad[gi])  + 4'(nxt_pad[gi+1])  + 4'(nxt_pad[gi+2]);

        assign rule_row[gi] = (n_live == 4'd3) || (curr_q[gi] && (n_live == 4'd2));
    end

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        curr_d      = curr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        row_cnt_d   = row_cnt_q;
        in_ready    = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            FILL: begin
                // The output register is always empty here (DRAIN emptied it),
                // so row 0 can be taken without any output-side condition.
                in_ready  = 1'b1;
                row_cnt_d = '0;
                if (in_valid) begin
                    curr_d    = in_data;
                    prev_d    = '0;
                    row_cnt_d = CNT_ONE;
                    state_d   = SINGLE_ROW ? FLUSH : RUN;
                end
            end

            RUN: begin
                in_ready = out_slot_free;
                if (in_valid && out_slot_free) begin
                    // If the old output leaves in this same cycle, the new
                    // output replaces it directly, with no empty cycle between.
                    out_data_d  = rule_row;
                    out_valid_d = 1'b1;
                    prev_d      = curr_q;
                    curr_d      = in_data;
                    row_cnt_d   = row_cnt_q + CNT_ONE;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = FLUSH;
                    end
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end

            FLUSH: begin
                if (out_slot_free) begin
                    out_data_d  = rule_row;
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end
            end

            DRAIN: begin
                // frame_done is combinational so that it goes high in the same
                // cycle as the last handshake. in_ready is 0 in that cycle.
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    frame_done  = 1'b1;
                    row_cnt_d   = '0;
                    state_d     = FILL;
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FILL;
            prev_q      <= '0;
            curr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            row_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            curr_q      <= curr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            row_cnt_q   <= row_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
